// File: rtl/oam_dma.sv
// oam_dma: $4014 sprite DMA that halts the CPU and copies one page into OAMDATA.
// State changes on the falling clock edge and only while i_ce is high.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
    parameter int          TRANSFER_LEN = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ce,
    input  logic [15:0] i_cpu_address,
    input  logic [7:0]  i_cpu_data,
    input  logic        i_cpu_rw,
    input  logic [7:0]  i_bus_data,
    output logic        o_rdy,
    output logic        o_bus_master,
    output logic [15:0] o_address,
    output logic        o_rw,
    output logic [7:0]  o_data,
    output logic        o_busy,
    output logic [7:0]  o_debug_index
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    localparam logic [7:0] LAST = 8'(TRANSFER_LEN - 1);

    state_t     state, state_n;
    logic [7:0] page, page_n, index, index_n;
    logic       parity;

    always_comb begin
        state_n = state;
        page_n  = page;
        index_n = index;
        if (i_ce)
            case (state)
                IDLE:
                    if (!i_cpu_rw && i_cpu_address == DMA_REG_ADDR) begin
                        state_n = HALT;
                        page_n  = i_cpu_data;
                        index_n = 8'h00;
                    end
                // reads must land on the get (parity 0) cycle
                HALT:  state_n = parity ? READ : ALIGN;
                ALIGN: state_n = READ;
                READ:  state_n = WRITE;
                WRITE: begin
                    index_n = index + 8'd1;
                    state_n = (index == LAST) ? IDLE : READ;
                end
                default: state_n = IDLE;
            endcase
    end

    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            page      <= 8'h00;
            index     <= 8'h00;
            parity    <= 1'b0;
            o_address <= 16'h0000;
            o_rw      <= 1'b1;
            o_data    <= 8'h00;
        end else if (i_ce) begin
            state     <= state_n;
            page      <= page_n;
            index     <= index_n;
            parity    <= ~parity;
            o_address <= (state_n == READ) ? {page_n, index_n} :
                         (state_n == WRITE) ? OAMDATA_ADDR : 16'h0000;
            o_rw      <= state_n != WRITE;
            o_data    <= (state == READ) ? i_bus_data : 8'h00;
        end
    end

    assign o_rdy         = state == IDLE;
    assign o_bus_master  = state == READ || state == WRITE;
    assign o_busy        = state != IDLE;
    assign o_debug_index = index;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: scoreboard bench for the sprite DMA engine.
module tb_oam_dma;
    logic        clk = 1'b0, rst = 1'b0, ce = 1'b0, cpu_rw = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data = 8'h00;
    logic [7:0]  bus_data, data, dbg_idx;
    logic [15:0] address;
    logic        rdy, bus_master, rw, busy;
    int          errors = 0, checks = 0;
    bit          par = 1'b0;
    logic [7:0]  sb[$];

    always #5 clk = ~clk;

    // memory: page 3 holds n^3C, every other page n^A5
    assign bus_data = address[7:0] ^ ((address[15:8] == 8'h03) ? 8'h3C : 8'hA5);

    oam_dma dut (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_cpu_address(cpu_addr),
        .i_cpu_data(cpu_data), .i_cpu_rw(cpu_rw), .i_bus_data(bus_data),
        .o_rdy(rdy), .o_bus_master(bus_master), .o_address(address), .o_rw(rw),
        .o_data(data), .o_busy(busy), .o_debug_index(dbg_idx)
    );

    task automatic step();
        @(posedge clk);
        #1;
        if (ce) par = ~par;
    endtask

    task automatic set_idle();
        cpu_addr = 16'h0000;
        cpu_rw   = 1'b1;
        cpu_data = 8'h00;
        ce       = 1'b1;
    endtask

    task automatic do_transfer(input logic [7:0] page, input bit want_par,
                               input int stall_at, input int abort_at, input bit poke);
        int low, idx, guard;
        logic [15:0] held_addr;
        logic [7:0]  held_idx, exp;
        set_idle();
        while (par != want_par) step();
        cpu_addr = 16'h4014;
        cpu_rw   = 1'b0;
        cpu_data = page;
        for (int n = 0; n < 256; n++) sb.push_back(8'(n) ^ ((page == 8'h03) ? 8'h3C : 8'hA5));
        step();
        set_idle();
        low = 0; idx = 0; guard = 0;
        while (rdy !== 1'b1 && guard < 1000) begin
            guard++;
            if (bus_master === 1'b1 && rw === 1'b1) begin
                checks++;
                if (address !== {page, 8'(idx)} || par !== 1'b0)
                    begin errors++; $display("FAIL read_addr idx=%0d: got %h par=%0d, want %h par=0", idx, address, par, {page, 8'(idx)}); end
                if (idx == stall_at) begin
                    held_addr = address;
                    held_idx  = dbg_idx;
                    ce = 1'b0;
                    repeat (5) begin
                        step();
                        checks++;
                        if (address !== held_addr || dbg_idx !== held_idx)
                            begin errors++; $display("FAIL stall_hold: got %h/%h, want %h/%h", address, dbg_idx, held_addr, held_idx); end
                    end
                    ce = 1'b1;
                end
                if (idx == abort_at) begin
                    rst = 1'b1;
                    #1;
                    checks++;
                    if (rdy !== 1'b1 || bus_master !== 1'b0 || dbg_idx !== 8'h00)
                        begin errors++; $display("FAIL abort: got rdy=%b master=%b idx=%h, want 1 0 00", rdy, bus_master, dbg_idx); end
                    ce = 1'b0;
                    step();
                    rst = 1'b0;
                    par = 1'b0;
                    set_idle();
                    sb.delete();
                    return;
                end
            end
            if (bus_master === 1'b1 && rw === 1'b0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL extra_write: got data %h, want no write", data);
                end else begin
                    exp = sb.pop_front();
                    if (address !== 16'h2004 || data !== exp)
                        begin errors++; $display("FAIL write idx=%0d: got %h:%h, want 2004:%h", idx, address, data, exp); end
                end
                idx++;
            end
            if (poke && low == 20) begin
                cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data = 8'h07;
            end else set_idle();
            low++;
            step();
        end
        set_idle();
        checks++;
        if (low != (want_par ? 514 : 513))
            begin errors++; $display("FAIL halt_len: got %0d, want %0d", low, want_par ? 514 : 513); end
        checks++;
        if (sb.size() != 0 || idx != 256)
            begin errors++; $display("FAIL write_count: got %0d writes, want 256", idx); end
        step();
        checks++;
        if (rdy !== 1'b1 || busy !== 1'b0 || bus_master !== 1'b0)
            begin errors++; $display("FAIL done_idle: got rdy=%b busy=%b master=%b, want 1 0 0", rdy, busy, bus_master); end
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        par = 1'b0;
        cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data = 8'h02; ce = 1'b1;
        step();
        set_idle();
        repeat (4) step();
        checks++;
        if (busy !== 1'b1 || rw !== 1'b0 || data !== 8'hA4)
            begin errors++; $display("FAIL pre_reset: got busy=%b rw=%b data=%h, want 1 0 a4", busy, rw, data); end
        rst = 1'b1;
        #1;
        checks++;
        if (rdy !== 1'b1 || bus_master !== 1'b0 || address !== 16'h0 || rw !== 1'b1 ||
            data !== 8'h0 || busy !== 1'b0 || dbg_idx !== 8'h0)
            begin errors++; $display("FAIL reset_vals: got rdy=%b m=%b a=%h rw=%b d=%h busy=%b i=%h, want 1 0 0000 1 00 0 00",
                                     rdy, bus_master, address, rw, data, busy, dbg_idx); end
        step();
        rst = 1'b0;
        par = 1'b0;
    endtask

    task automatic test_even();   do_transfer(8'h02, 1'b0, -1, -1, 1'b0); endtask
    task automatic test_odd();    do_transfer(8'h02, 1'b1, -1, -1, 1'b0); endtask
    task automatic test_stall();  do_transfer(8'h02, 1'b0, 37, -1, 1'b0); endtask
    task automatic test_busy_write(); do_transfer(8'h02, 1'b1, -1, -1, 1'b1); endtask

    task automatic test_abort();
        do_transfer(8'h02, 1'b0, -1, 100, 1'b0);
        do_transfer(8'h03, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_non_trigger();
        set_idle();
        cpu_addr = 16'h4014; cpu_rw = 1'b1; cpu_data = 8'h02;
        step();
        set_idle();
        checks++;
        if (busy !== 1'b0 || rdy !== 1'b1)
            begin errors++; $display("FAIL read_4014: got busy=%b rdy=%b, want 0 1", busy, rdy); end
        cpu_addr = 16'h4015; cpu_rw = 1'b0; cpu_data = 8'h02;
        step();
        set_idle();
        checks++;
        if (busy !== 1'b0 || rdy !== 1'b1)
            begin errors++; $display("FAIL write_4015: got busy=%b rdy=%b, want 0 1", busy, rdy); end
        cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data = 8'h02; ce = 1'b0;
        step();
        set_idle();
        checks++;
        if (busy !== 1'b0 || rdy !== 1'b1)
            begin errors++; $display("FAIL ce_low_write: got busy=%b rdy=%b, want 0 1", busy, rdy); end
    endtask

    initial begin
        test_reset();
        test_even();
        test_odd();
        test_abort();
        test_stall();
        test_non_trigger();
        test_busy_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- CPU-side OAM DMA engine (the $4014 sprite DMA). Sits directly upstream of the PPU OAM port.
- On a CPU write to the DMA register, it halts the CPU and becomes bus master. It then copies 256 bytes from CPU page {data,8'h00} into the PPU through OAMDATA ($2004) writes.
- It replaces the 256 CPU-driven OAMDATA writes that sprite setup would otherwise need.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA
- OAMDATA_ADDR, 16'h2004, destination address for every write cycle
- TRANSFER_LEN, 256, number of bytes copied per DMA (must be a power of two, ≤256)

Ports:
- i_clk  in  1  system clock; all state updates on falling edge, like the PPU register interface
- i_reset  in  1  asynchronous, active-high reset
- i_ce  in  1  clock enable (CPU cycle strobe); no state, counter or parity change when low
- i_cpu_address  in  16  CPU address bus (CPU as master)
- i_cpu_data  in  8  CPU write data
- i_cpu_rw  in  1  CPU read/~write
- i_bus_data  in  8  data read from system bus during DMA read cycles
- o_rdy  out  1  to CPU RDY; 0 halts CPU
- o_bus_master  out  1  1 = DMA drives system address/rw/data
- o_address  out  16  DMA bus address
- o_rw  out  1  DMA read/~write
- o_data  out  8  DMA write data (valid when o_rw=0)
- o_busy  out  1  DMA in progress (any state except IDLE)
- o_debug_index  out  8  current byte index

Behaviour:
- Reset (async, any time including mid-transfer):
  - Outputs: o_rdy=1, o_bus_master=0, o_address=0, o_rw=1, o_data=0, o_busy=0, o_debug_index=0.
  - Internal: state=IDLE, page=0, parity=0.
- Parity:
  - 1-bit register toggles on every i_ce cycle from reset.
  - Models the CPU get/put cycle: READ cycles always have parity=0, WRITE cycles parity=1.
- Trigger:
  - Condition: in IDLE with i_ce=1, i_cpu_rw=0 and i_cpu_address==DMA_REG_ADDR.
  - Action: latch page=i_cpu_data, index=0, go to HALT.
  - Not triggers: reads of DMA_REG_ADDR and writes to any other address.
  - Triggers while not IDLE are ignored; the CPU is halted and the DMA never addresses DMA_REG_ADDR.
- States, each advancing once per i_ce cycle:
  - IDLE: o_rdy=1, o_bus_master=0, o_rw=1.
  - HALT:
    - Outputs: o_rdy=0, o_bus_master=0; one dummy cycle letting the CPU finish its current access.
    - Next state is READ if parity==1 during HALT, else ALIGN.
  - ALIGN: o_rdy=0, o_bus_master=0; one extra dummy cycle, then READ.
  - READ:
    - Outputs: o_rdy=0, o_bus_master=1, o_rw=1, o_address={page,index}.
    - i_bus_data is latched into the data register at end of cycle, then WRITE.
  - WRITE:
    - Outputs: o_rdy=0, o_bus_master=1, o_rw=0, o_address=OAMDATA_ADDR, o_data=latched byte.
    - At end of cycle, index increments.
    - If index was TRANSFER_LEN-1, go to IDLE; o_rdy=1 and o_bus_master=0 on the following cycle. Otherwise go to READ.
- Cycle count: HALT through final WRITE is 1+2*TRANSFER_LEN when the trigger cycle has parity 0 (513), and 2+2*TRANSFER_LEN when it has parity 1 (514).
- Index wraps naturally (8-bit). Source address never crosses the page boundary: {page,8'hFF} is the last byte.
- o_address, o_rw and o_data are registered; they reflect the current state with no combinational path from CPU inputs.
- OAM address ownership: the PPU's OAMADDR auto-increment handles destination placement. This block never writes OAMADDR.
- i_ce=0: all registers hold, and outputs stay stable for the entire stall.

Test Plan:
- Reset check: assert i_reset mid-simulation → all outputs at reset values immediately, without waiting for a clock edge.
- Even-parity trigger: memory page $02 filled with pattern (byte n = n^8'hA5); CPU writes $02 to $4014 on a parity-0 cycle.
  - Required: o_rdy low for exactly 513 ce cycles.
  - First READ address $0200; 256 WRITEs to $2004 with data n^A5 in order.
  - Last write data $5A (n=$FF); o_rdy returns high.
- Odd-parity trigger: same as previous but trigger on a parity-1 cycle → ALIGN cycle present, o_rdy low for 514 cycles, all READ cycles have parity 0.
- Reset mid-operation: assert i_reset after index=100 → o_bus_master=0 and o_rdy=1 at once. A new trigger with page $03 restarts at address $0300, index 0.
- Clock-enable stall: i_ce held low for 5 cycles during a READ → o_address held at the same value, index unchanged; transfer completes with the correct 513 ce-cycle count.
- Non-trigger accesses: CPU read of $4014, write to $4015, and write to $4014 while busy → no new DMA; an active transfer is unaffected.
